tour_cmd: RTL and testbench
===========================

Name: tour_cmd

Overview:
- Initiator-side command generator for the command processor.
- On a tour start, walks the solved knight's-tour move list and turns each one-hot knight move into two 16-bit move commands: vertical leg, then horizontal leg with fanfare.
- Drives the command_ready/clear handshake and waits for each send_response before issuing the next command.
- Outside a tour it passes UART/BLE commands straight through, so it sits between the UART wrapper and the command processor.

Parameters:
- NUM_MOVES, 24: number of knight moves in a tour. mv_indx counts 0..NUM_MOVES-1.

Ports:
- clk  in  1  50MHz system clock
- rst_n  in  1  synchronous active-low reset
- start_tour  in  1  one-clk pulse (tour_go) that starts the tour
- move  in  8  one-hot knight move for the current mv_indx; combinational read of the move store
- mv_indx  out  5  index of the move being fetched/executed
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  UART command consumed
- cmd  out  16  command to command processor
- cmd_rdy  out  1  command valid to command processor
- clr_cmd_rdy  in  1  command processor consumed cmd
- send_resp  in  1  command processor finished a command
- resp  out  8  response byte to UART wrapper

Behaviour:
- Reset (rst_n low at posedge clk):
  - state=IDLE, mv_indx=0, move_q=0.
  - Outputs follow the IDLE mux: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5.
  - Reset mid-tour aborts the tour immediately; no command is completed.
- States: IDLE, FETCH, VERT_RDY, VERT_RESP, HORZ_RDY, HORZ_RESP.
- IDLE:
  - UART pass-through: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5.
  - start_tour -> mv_indx<=0, go FETCH.
- Non-IDLE states:
  - cmd_rdy_UART is ignored and clr_cmd_rdy_UART=0.
  - start_tour is ignored.
- FETCH (1 clk): move_q<=move.
  - If move==0, abort to IDLE (no command issued).
  - Otherwise go VERT_RDY.
  - Multi-hot move: lowest set bit wins.
- VERT_RDY: cmd=vertical command, cmd_rdy=1. On clr_cmd_rdy go VERT_RESP; cmd_rdy drops the next cycle.
- VERT_RESP: cmd_rdy=0, cmd held. On send_resp go HORZ_RDY, resp=8'h5A.
- HORZ_RDY / HORZ_RESP: same handshake as VERT_RDY / VERT_RESP, using the horizontal command.
  - On send_resp with mv_indx==NUM_MOVES-1: resp=8'hA5, go IDLE.
  - Otherwise: resp=8'h5A, mv_indx<=mv_indx+1, go FETCH.
- send_resp seen in a *_RDY state is ignored. clr_cmd_rdy seen in a *_RESP state is ignored.
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Vertical leg: opcode 4'h2.
  - Horizontal leg: opcode 4'h3 (move with fanfare).
  - Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
- Decode as bit: vertical cmd, horizontal cmd:
  - bit0 up2/left1: 16'h2002, 16'h33F1
  - bit1 up2/right1: 16'h2002, 16'h3BF1
  - bit2 left2/up1: 16'h2001, 16'h33F2
  - bit3 left2/down1: 16'h27F1, 16'h33F2
  - bit4 down2/left1: 16'h27F2, 16'h33F1
  - bit5 down2/right1: 16'h27F2, 16'h3BF1
  - bit6 right2/down1: 16'h27F1, 16'h3BF2
  - bit7 right2/up1: 16'h2001, 16'h3BF2
- cmd must be stable for the whole of every *_RDY and *_RESP state.
- The opcode/heading/squares of cmd are decoded from move_q only, never from the live move input.

Test Plan:
- Reset: rst_n low 2 clks with cmd_UART=16'h4000, cmd_rdy_UART=1 -> state IDLE, mv_indx=0, cmd=16'h4000, cmd_rdy=1, resp=8'hA5. Then clr_cmd_rdy=1 -> clr_cmd_rdy_UART=1 same clk.
- Single move: move=8'h01, start_tour, command-processor model clears after 3 clks and responds after 20.
  - Required order: cmd 16'h2002 with cmd_rdy, cmd_rdy low the clk after clear, resp 8'h5A.
  - Then cmd 16'h33F1, resp 8'h5A, mv_indx 0->1.
- Full tour: NUM_MOVES=24, move store cycling all 8 encodings -> exactly 48 commands matching the decode table, in order. mv_indx reaches 23 and never 24. Final resp=8'hA5; IDLE pass-through restored.
- Isolation: cmd_rdy_UART=1 and start_tour pulses during a tour -> clr_cmd_rdy_UART stays 0, tour unaffected. UART command passed through after completion.
- Protocol abuse: send_resp during VERT_RDY -> ignored, state unchanged. move=8'h00 at FETCH -> return to IDLE with cmd_rdy sourced from UART, no tour command issued.
- Reset mid-tour: rst_n low during HORZ_RESP of move 5 -> next clk IDLE, mv_indx=0, cmd_rdy follows cmd_rdy_UART. A new start_tour restarts from move 0.

Source files
------------

// File: rtl/tour_cmd.sv
// tour_cmd: initiator-side command generator sitting between the UART
// wrapper and the command processor. Outside a tour it passes UART
// commands straight through. During a tour it walks the knight's-tour
// move list and turns each one-hot move into a vertical command followed
// by a horizontal command with fanfare.
module tour_cmd #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    VERT_RDY  = 3'd2,
    VERT_RESP = 3'd3,
    HORZ_RDY  = 3'd4,
    HORZ_RESP = 3'd5
  } state_t;

  localparam logic [4:0] LAST_IDX  = 5'(NUM_MOVES - 1);
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_ACK  = 8'h5A;

  state_t      state_r;
  state_t      state_s;
  logic [4:0]  mv_indx_r;
  logic [7:0]  move_q_r;
  logic [7:0]  resp_r;
  logic [31:0] legs_s;
  logic [15:0] vert_cmd_s;
  logic [15:0] horz_cmd_s;

  // Map a knight move to {vertical cmd, horizontal cmd}; lowest set bit wins.
  // Vertical legs use opcode 2, horizontal legs opcode 3 (move with fanfare).
  // Headings: north 00, west 3F, south 7F, east BF.
  function automatic logic [31:0] decode_move(input logic [7:0] mv);
    logic [31:0] legs;
    legs = 32'h0000_0000;
    if (mv[0])      legs = {16'h2002, 16'h33F1};  // up2 / left1
    else if (mv[1]) legs = {16'h2002, 16'h3BF1};  // up2 / right1
    else if (mv[2]) legs = {16'h2001, 16'h33F2};  // left2 / up1
    else if (mv[3]) legs = {16'h27F1, 16'h33F2};  // left2 / down1
    else if (mv[4]) legs = {16'h27F2, 16'h33F1};  // down2 / left1
    else if (mv[5]) legs = {16'h27F2, 16'h3BF1};  // down2 / right1
    else if (mv[6]) legs = {16'h27F1, 16'h3BF2};  // right2 / down1
    else if (mv[7]) legs = {16'h2001, 16'h3BF2};  // right2 / up1
    else            legs = 32'h0000_0000;
    return legs;
  endfunction

  // Commands come only from the latched move so they stay stable while
  // the move store is free to change underneath.
  assign legs_s     = decode_move(move_q_r);
  assign vert_cmd_s = legs_s[31:16];
  assign horz_cmd_s = legs_s[15:0];
  assign mv_indx    = mv_indx_r;

  // Next-state logic and output mux (UART pass-through only in IDLE).
  always_comb begin
    state_s          = state_r;
    cmd              = vert_cmd_s;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = resp_r;
    case (state_r)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        if (start_tour) state_s = FETCH;
        else            state_s = IDLE;
      end
      FETCH: begin
        if (move == 8'h00) state_s = IDLE;
        else               state_s = VERT_RDY;
      end
      VERT_RDY: begin
        cmd     = vert_cmd_s;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_s = VERT_RESP;
        else             state_s = VERT_RDY;
      end
      VERT_RESP: begin
        cmd = vert_cmd_s;
        if (send_resp) state_s = HORZ_RDY;
        else           state_s = VERT_RESP;
      end
      HORZ_RDY: begin
        cmd     = horz_cmd_s;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_s = HORZ_RESP;
        else             state_s = HORZ_RDY;
      end
      HORZ_RESP: begin
        cmd = horz_cmd_s;
        if (!send_resp)                  state_s = HORZ_RESP;
        else if (mv_indx_r == LAST_IDX)  state_s = IDLE;
        else                             state_s = FETCH;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, move index, latched move and response byte registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mv_indx_r <= 5'd0;
      move_q_r  <= 8'h00;
      resp_r    <= RESP_DONE;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (start_tour) begin
            mv_indx_r <= 5'd0;
            resp_r    <= RESP_DONE;
          end
        end
        FETCH: begin
          move_q_r <= move;
        end
        VERT_RESP: begin
          if (send_resp) resp_r <= RESP_ACK;
        end
        HORZ_RESP: begin
          if (send_resp) begin
            if (mv_indx_r == LAST_IDX) begin
              resp_r <= RESP_DONE;
            end else begin
              resp_r    <= RESP_ACK;
              mv_indx_r <= mv_indx_r + 5'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd. Expected commands come from a
// displacement model of each knight move (dy, dx), not from a table
// copy of the RTL's decoder.
module tb_tour_cmd;

  localparam int NUM_MOVES = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0]  mem [NUM_MOVES];
  int          errors = 0;
  int          checks = 0;
  int          n_cmds = 0;
  int          max_idx = 0;
  bit          noise = 1'b0;

  tour_cmd #(.NUM_MOVES(NUM_MOVES)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
    .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp)
  );

  always #10 clk = ~clk;

  // Move store: combinational read at mv_indx.
  always_comb move = (int'(mv_indx) < NUM_MOVES) ? mem[mv_indx] : 8'h00;

  // Track the highest index ever presented.
  always @(negedge clk) if (int'(mv_indx) > max_idx) max_idx = int'(mv_indx);

  // Reference: knight displacement of the lowest set bit, then build the
  // vertical leg (north/south) and horizontal leg (west/east).
  function automatic logic [31:0] model_legs(input logic [7:0] m);
    int b, dy, dx;
    logic [7:0] hv, hh;
    b = -1;
    for (int i = 7; i >= 0; i--) if (m[i]) b = i;
    case (b)
      0: begin dy =  2; dx = -1; end
      1: begin dy =  2; dx =  1; end
      2: begin dy =  1; dx = -2; end
      3: begin dy = -1; dx = -2; end
      4: begin dy = -2; dx = -1; end
      5: begin dy = -2; dx =  1; end
      6: begin dy = -1; dx =  2; end
      7: begin dy =  1; dx =  2; end
      default: begin dy = 0; dx = 0; end
    endcase
    hv = (dy > 0) ? 8'h00 : 8'h7F;
    hh = (dx < 0) ? 8'h3F : 8'hBF;
    return {4'h2, hv, 4'((dy < 0) ? -dy : dy), 4'h3, hh, 4'((dx < 0) ? -dx : dx)};
  endfunction

  task automatic drive_noise();
    start_tour = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (noise) cmd_rdy_UART = 1'b1;
  endtask

  // One command handshake as the command processor; leaves just after the
  // send_resp edge (or in the *_RESP state when give_resp is 0).
  task automatic leg(input logic [15:0] exp, input int cd, input int rd,
                     input int idx, input bit give_resp, input string nm);
    int w;
    w = 0;
    while (cmd_rdy !== 1'b1 && w < 20) begin
      drive_noise(); @(negedge clk); w++;
    end
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL %s_rdy_timeout cmd_rdy=%b required 1", nm, cmd_rdy);
      return;
    end
    checks++;
    if (cmd !== exp) begin
      errors++; $display("FAIL %s_cmd got %h required %h", nm, cmd, exp);
    end
    checks++;
    if (int'(mv_indx) !== idx) begin
      errors++; $display("FAIL %s_idx got %0d required %0d", nm, mv_indx, idx);
    end
    n_cmds++;
    repeat (cd) begin
      drive_noise(); @(negedge clk);
      checks++;
      if (cmd !== exp || cmd_rdy !== 1'b1) begin
        errors++; $display("FAIL %s_hold cmd=%h rdy=%b required %h/1", nm, cmd, cmd_rdy, exp);
      end
    end
    clr_cmd_rdy = 1'b1;
    drive_noise();
    #1;
    checks++;
    if (clr_cmd_rdy_UART !== 1'b0) begin
      errors++; $display("FAIL %s_uart_clr got %b required 0", nm, clr_cmd_rdy_UART);
    end
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== exp) begin
      errors++; $display("FAIL %s_drop cmd=%h rdy=%b required %h/0", nm, cmd, cmd_rdy, exp);
    end
    repeat (rd) begin
      drive_noise(); @(negedge clk);
      checks++;
      if (cmd !== exp || cmd_rdy !== 1'b0) begin
        errors++; $display("FAIL %s_wait cmd=%h rdy=%b required %h/0", nm, cmd, cmd_rdy, exp);
      end
    end
    if (give_resp) begin
      send_resp = 1'b1; drive_noise();
      @(negedge clk);
      send_resp = 1'b0;
    end
  endtask

  // Full move: vertical then horizontal leg, with response checks.
  task automatic run_move(input int i, input int cd, input int rd);
    logic [31:0] legs;
    legs = model_legs(mem[i]);
    leg(legs[31:16], cd, rd, i, 1'b1, "vert");
    checks++;
    if (resp !== 8'h5A) begin
      errors++; $display("FAIL vert_resp got %h required 5a", resp);
    end
    leg(legs[15:0], cd, rd, i, 1'b1, "horz");
    start_tour = 1'b0;
    if (i == NUM_MOVES - 1) begin
      #1;
      checks++;
      if (resp !== 8'hA5 || cmd !== cmd_UART || cmd_rdy !== cmd_rdy_UART) begin
        errors++; $display("FAIL tour_end resp=%h cmd=%h rdy=%b required a5/%h/%b",
                           resp, cmd, cmd_rdy, cmd_UART, cmd_rdy_UART);
      end
    end else begin
      checks++;
      if (resp !== 8'h5A || int'(mv_indx) !== i + 1) begin
        errors++; $display("FAIL next_move resp=%h idx=%0d required 5a/%0d", resp, mv_indx, i + 1);
      end
    end
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
  endtask

  // After a move whose successor is 8'h00: FETCH then back to IDLE.
  task automatic expect_abort(input string nm);
    cmd_rdy_UART = 1'b1;
    cmd_UART = 16'($urandom);
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL %s_fetch cmd_rdy got %b required 0", nm, cmd_rdy);
    end
    @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== cmd_UART || resp !== 8'hA5) begin
      errors++; $display("FAIL %s_idle cmd=%h rdy=%b resp=%h required %h/1/a5",
                         nm, cmd, cmd_rdy, resp, cmd_UART);
    end
    cmd_rdy_UART = 1'b0;
    #1;
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL %s_passthru cmd_rdy got %b required 0", nm, cmd_rdy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_UART = 16'h4000; cmd_rdy_UART = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd !== 16'h4000 || cmd_rdy !== 1'b1 || resp !== 8'hA5 || mv_indx !== 5'd0) begin
      errors++; $display("FAIL reset cmd=%h rdy=%b resp=%h idx=%0d required 4000/1/a5/0",
                         cmd, cmd_rdy, resp, mv_indx);
    end
    checks++;
    if (clr_cmd_rdy_UART !== 1'b0) begin
      errors++; $display("FAIL reset_clr got %b required 0", clr_cmd_rdy_UART);
    end
    clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (clr_cmd_rdy_UART !== 1'b1) begin
      errors++; $display("FAIL reset_clr_pass got %b required 1", clr_cmd_rdy_UART);
    end
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_move();
    mem[0] = 8'h01; mem[1] = 8'h00;
    pulse_start();
    run_move(0, 3, 20);
    expect_abort("single");
  endtask

  task automatic test_abuse();
    int w;
    mem[0] = 8'hF4; mem[1] = 8'h00;   // multi-hot: bit2 wins
    pulse_start();
    w = 0;
    while (cmd_rdy !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h2001 || resp !== 8'hA5) begin
      errors++; $display("FAIL abuse_resp_in_rdy cmd=%h rdy=%b resp=%h required 2001/1/a5",
                         cmd, cmd_rdy, resp);
    end
    run_move(0, 1, 2);
    expect_abort("abuse");
  endtask

  task automatic test_full_tour();
    int off;
    off = int'($urandom_range(0, 7));
    for (int i = 0; i < NUM_MOVES; i++) begin
      mem[i] = 8'(1 << ((i + off) % 8));
      if ($urandom_range(0, 3) == 0) mem[i] = mem[i] | (mem[i] << 1);
    end
    n_cmds = 0; max_idx = 0;
    pulse_start();
    noise = 1'b1;
    for (int i = 0; i < NUM_MOVES; i++)
      run_move(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
    noise = 1'b0; start_tour = 1'b0;
    checks++;
    if (n_cmds !== 2 * NUM_MOVES || max_idx !== NUM_MOVES - 1) begin
      errors++; $display("FAIL tour_count cmds=%0d max_idx=%0d required %0d/%0d",
                         n_cmds, max_idx, 2 * NUM_MOVES, NUM_MOVES - 1);
    end
    cmd_UART = 16'($urandom); cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (cmd !== cmd_UART || cmd_rdy !== 1'b1 || clr_cmd_rdy_UART !== 1'b1) begin
      errors++; $display("FAIL post_tour_pass cmd=%h rdy=%b clr=%b required %h/1/1",
                         cmd, cmd_rdy, clr_cmd_rdy_UART, cmd_UART);
    end
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] legs;
    for (int i = 0; i < NUM_MOVES; i++) mem[i] = 8'(1 << $urandom_range(0, 7));
    pulse_start();
    for (int i = 0; i < 5; i++) run_move(i, 1, 1);
    legs = model_legs(mem[5]);
    leg(legs[31:16], 0, 1, 5, 1'b1, "mid_vert");
    leg(legs[15:0], 0, 2, 5, 1'b0, "mid_horz");
    rst_n = 1'b0; cmd_rdy_UART = 1'b1; cmd_UART = 16'h1234;
    @(negedge clk);
    checks++;
    if (mv_indx !== 5'd0 || cmd_rdy !== 1'b1 || cmd !== 16'h1234 || resp !== 8'hA5) begin
      errors++; $display("FAIL mid_reset idx=%0d rdy=%b cmd=%h resp=%h required 0/1/1234/a5",
                         mv_indx, cmd_rdy, cmd, resp);
    end
    cmd_rdy_UART = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    mem[1] = 8'h00;
    pulse_start();
    run_move(0, 0, 0);
    expect_abort("restart");
  endtask

  initial begin
    rst_n = 1'b0; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    for (int i = 0; i < NUM_MOVES; i++) mem[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_move();
    test_abuse();
    test_full_tour();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
